// File: rtl/hash_block_reader.sv
// Avalon-MM read master: streams a contiguous block of 32-bit RAM words to the
// hash core over valid/ready, absorbing the one-cycle read latency in a small FIFO.
module hash_block_reader #(
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              inflight_last;

  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              pop;
  logic              push;
  logic              issue;
  logic              last_issue;
  logic [CNT_W:0]    occ_after;

  assign pop  = out_valid & out_ready;
  assign push = inflight;

  // Occupancy once this cycle's pop is gone, counting the word still on its way from RAM.
  assign occ_after  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign issue      = (state == RUN) && (occ_after < (CNT_W+1)'(FIFO_DEPTH));
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_nxt = DRAIN;
        end
      end
      // Leaving on the out_last handshake lets done follow it by exactly one cycle.
      DRAIN: begin
        if ((pop && out_last) || (fifo_count == '0 && !inflight)) begin
          state_nxt = FIN;
        end
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= last_issue;
      if (state == IDLE && start) begin
        cur_addr  <= base_addr;
        remaining <= word_count;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked entirely by fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_readdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign mem_address    = cur_addr;
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;
  assign out_valid      = (fifo_count != '0);
  assign out_data       = fifo_data[rd_ptr];
  assign out_last       = out_valid && fifo_last[rd_ptr];

endmodule
